// File: rtl/divider_control_unit_pkg.sv
// Shared types for the divider control path: FSM state encoding and the
// control strobe bundle handed to the shift-subtract datapath.
package divider_control_unit_pkg;

  localparam int DIVIDER_STATE_WIDTH = 3;

  typedef enum logic [DIVIDER_STATE_WIDTH-1:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    STOP  = 3'd5
  } DIVIDER_STATE;

  // Bit order matters: the datapath sees {load, shift, sync_rst, ready, ctrl_stop}.
  typedef struct packed {
    logic load;
    logic shift;
    logic sync_rst;
    logic ready;
    logic ctrl_stop;
  } DIVIDER_CONTROL_SIGNALS;

  localparam logic [4:0] DIVIDER_CTRL_IDLE = 5'b00010;

endpackage

// File: rtl/divider_iteration_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
// Wraps to zero after COUNT_MAX-1. Shared by the divider and sqrt sequencers.
module divider_iteration_counter #(
  parameter int unsigned COUNT_MAX = 16,
  parameter int unsigned COUNT_W   = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               enable_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               tc_o
);

  localparam logic [COUNT_W-1:0] LastCount = COUNT_W'(COUNT_MAX - 1);

  logic [COUNT_W-1:0] count_q, count_d;

  assign tc_o    = (count_q == LastCount);
  assign count_o = count_q;

  // Clear wins over enable; enabled count wraps after the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tc_o ? '0 : count_q + COUNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/divider_control_unit.sv
// Sequencer for the shift-subtract divider: clear, load, WORD_LENGTH shift
// iterations, then a one-cycle done. Divide-by-zero or stop_req abort via STOP.
//
// state | meaning
// IDLE  | ready for a new request, waits for start
// CLEAR | sync_rst to datapath, one cycle
// LOAD  | load operands, divisor_is_zero sampled at exit
// SHIFT | one shift/subtract per cycle, WORD_LENGTH cycles
// DONE  | result valid, done pulse
// STOP  | ctrl_stop pulse after abort, back to IDLE
module divider_control_unit
  import divider_control_unit_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop_req,
  input  logic                           divisor_is_zero,
  output DIVIDER_CONTROL_SIGNALS         ctrl,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(WORD_LENGTH)-1:0] iter_count
);

  localparam int unsigned IterW = $clog2(WORD_LENGTH);

  DIVIDER_STATE state_q, state_d;
  logic         iter_tc;
  logic         iter_clear;
  logic         iter_enable;

  // The counter holds zero everywhere except across SHIFT, so it is already
  // zero in LOAD, after completion, and after an abort.
  assign iter_clear  = (state_d != SHIFT);
  assign iter_enable = (state_q == SHIFT);

  divider_iteration_counter #(
    .COUNT_MAX (WORD_LENGTH),
    .COUNT_W   (IterW)
  ) u_iter_cnt (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (iter_clear),
    .enable_i (iter_enable),
    .count_o  (iter_count),
    .tc_o     (iter_tc)
  );

  // State register; reset forces IDLE so all Moore outputs follow at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop_req outranks divide-by-zero and shift completion.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? CLEAR : IDLE;
      CLEAR:   state_d = stop_req ? STOP : LOAD;
      LOAD:    state_d = (stop_req || divisor_is_zero) ? STOP : SHIFT;
      SHIFT: begin
        if (stop_req) begin
          state_d = STOP;
        end else if (iter_tc) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    ctrl = '0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE:  ctrl.ready = 1'b1;
      CLEAR: begin
        ctrl.sync_rst = 1'b1;
        busy          = 1'b1;
      end
      LOAD: begin
        ctrl.load = 1'b1;
        busy      = 1'b1;
      end
      SHIFT: begin
        ctrl.shift = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        ctrl.ready = 1'b1;
        done       = 1'b1;
      end
      STOP: begin
        ctrl.ctrl_stop = 1'b1;
        busy           = 1'b1;
      end
      default: begin
        ctrl = '0;
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_divider_control_unit.sv
// Scoreboard bench for divider_control_unit. The driver computes, per request,
// the expected outcome (done or stop, shift/load counts, timing) from the
// published latency rules and queues it; a monitor reconstructs each operation
// from the control strobes and compares when the operation ends.
module tb_divider_control_unit;

  localparam int WL = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop_req = 1'b0;
  logic       divisor_is_zero = 1'b0;
  logic [4:0] ctrl;
  logic       busy;
  logic       done;
  logic [3:0] iter_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit is_done;
    int shifts;
    int loads;
    int s;
    int len;
  } exp_t;

  exp_t exp_q[$];

  divider_control_unit #(.WORD_LENGTH(WL)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop_req        (stop_req),
    .divisor_is_zero (divisor_is_zero),
    .ctrl            (ctrl),
    .busy            (busy),
    .done            (done),
    .iter_count      (iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: rebuild each operation from ctrl strobes, compare at its end.
  bit   in_op = 0;
  int   t0, nshift, nload;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      in_op = 0;
    end else if (!in_op) begin
      if (ctrl[2]) begin
        in_op  = 1;
        t0     = cyc;
        nshift = 0;
        nload  = 0;
        chk("clear_ctrl", ctrl, 5'b00100);
        chk("clear_busy", busy, 1);
      end else begin
        chk("idle_ctrl", ctrl, 5'b00010);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_iter", iter_count, 0);
      end
    end else begin
      chk("op_no_sync_rst", ctrl[2], 0);
      if (ctrl[4]) nload++;
      if (ctrl[3]) begin
        chk("shift_iter", iter_count, nshift);
        nshift++;
      end
      if (done || ctrl[0]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op_end: got an end at cyc %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("op_start", t0, e.s);
          chk("op_len", cyc - t0, e.len);
          chk("op_is_done", done, e.is_done);
          chk("op_shifts", nshift, e.shifts);
          chk("op_loads", nload, e.loads);
          if (e.is_done) begin
            chk("done_ctrl", ctrl, 5'b00010);
            chk("done_busy", busy, 0);
            chk("done_iter", iter_count, 0);
          end else begin
            chk("stop_ctrl", ctrl, 5'b00001);
            chk("stop_busy", busy, 1);
          end
        end
        in_op = 0;
      end else begin
        chk("op_busy", busy, 1);
        chk("op_ready", ctrl[1], 0);
        if (cyc - t0 > 40) begin
          checks++;
          errors++;
          $display("FAIL op_timeout: got %0d cycles expected <= 40", cyc - t0);
          in_op = 0;
        end
      end
    end
  end

  // Invariants every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert ($countones({ctrl[4], ctrl[3], ctrl[2], ctrl[0]}) <= 1)
      else begin
        errors++;
        $display("FAIL strobe_exclusive: got ctrl=%b expected at most one strobe", ctrl);
      end
      checks++;
      assert (!(busy && ctrl[1]))
      else begin
        errors++;
        $display("FAIL busy_ready_exclusive: got busy=%b ready=%b expected not both", busy, ctrl[1]);
      end
    end
  end

  // kind: 0 normal, 1 divide-by-zero, 2 abort in CLEAR, 3 abort in LOAD,
  // 4 abort in shift cycle k. gap = extra IDLE edges after the end state.
  task automatic run_op(input int kind, input int k, input int gap, input bit hold);
    exp_t x;
    int   L;
    int   abort_off;
    logic st, sp, z;
    x.loads     = 1;
    x.shifts    = 0;
    x.is_done   = 0;
    abort_off   = -1;
    case (kind)
      0: begin x.shifts = WL; x.is_done = 1; x.len = WL + 2; end
      1: x.len = 2;
      2: begin x.loads = 0; x.len = 1; abort_off = 1; end
      3: begin x.len = 2; abort_off = 2; end
      default: begin x.shifts = k + 1; x.len = 3 + k; abort_off = 3 + k; end
    endcase
    L = x.len + 1;
    if (hold) gap = 0;
    for (int off = 0; off <= L + gap; off++) begin
      if (hold || off == 0)  st = 1'b1;
      else if (off <= L)     st = 1'($urandom_range(0, 1));
      else                   st = 1'b0;
      sp = 1'b0;
      if (off == 0 || off >= L) sp = 1'($urandom_range(0, 1));
      if (off == abort_off)     sp = 1'b1;
      z = 1'($urandom_range(0, 1));
      if (off == 2 && kind != 3) z = (kind == 1);
      start           = st;
      stop_req        = sp;
      divisor_is_zero = z;
      @(posedge clk);
      #1;
      if (off == 0) begin
        x.s = cyc;
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic reset_mid_shift();
    start           = 1'b1;
    stop_req        = 1'b0;
    divisor_is_zero = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    chk("pre_reset_iter", iter_count, 9);
    chk("pre_reset_shift", ctrl[3], 1);
    reset = 1'b0;
    #1;
    chk("async_rst_ctrl", ctrl, 5'b00010);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_iter", iter_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int kind, k, gap;
    bit hold;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", ctrl, 5'b00010);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_iter", iter_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 0, 1, 0);
    run_op(1, 0, 1, 0);
    run_op(4, 4, 1, 0);
    run_op(4, WL - 1, 1, 0);
    run_op(4, 0, 0, 0);
    run_op(2, 0, 2, 0);
    run_op(3, 0, 1, 0);
    run_op(0, 0, 0, 1);
    run_op(0, 0, 0, 1);
    run_op(1, 0, 0, 1);
    run_op(0, 0, 2, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      k    = $urandom_range(0, WL - 1);
      gap  = $urandom_range(0, 2);
      hold = (gap == 0) && ($urandom_range(0, 1) == 1);
      run_op(kind, k, gap, hold);
    end
    run_op(0, 0, 2, 0);

    reset_mid_shift();
    run_op(0, 0, 2, 0);

    start    = 1'b0;
    stop_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
